// File: rtl/frame_draw_scheduler_pkg.sv
// frame_draw_scheduler_pkg: shared state encoding, screen/timing defaults and colour constants.
package frame_draw_scheduler_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_TICK,
    DRAW_CAT,
    DRAW_OBJ,
    FRAME_END
  } state_e;
  localparam int TICKS_PER_FRAME_DEF = 833334;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int MAX_DRAW_CYCLES_DEF = 1024;
  localparam int ARM_CYCLES_DEF = 2;
  localparam logic [2:0] BLACK = 3'b000;
  function automatic logic is_draw(state_e s);
    return s == DRAW_CAT || s == DRAW_OBJ;
  endfunction
endpackage

// File: rtl/frame_draw_scheduler_tick_gen.sv
// frame_tick_gen: free-running frame counter, tick high in the cycle it wraps to zero.
module frame_tick_gen #(
  parameter int TICKS_PER_FRAME = 833334
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic tick_o
);
  localparam int W = TICKS_PER_FRAME > 1 ? $clog2(TICKS_PER_FRAME) : 1;
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(TICKS_PER_FRAME - 1);
  always_ff @(posedge clock_i) begin
    if (reset_i) cnt_q <= '0;
    else cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler: per-frame clear/catcher/object sequencer and VGA pixel-bus arbiter
// with a per-client watchdog and one-deep pending-tick flag.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int TICKS_PER_FRAME = TICKS_PER_FRAME_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int MAX_DRAW_CYCLES = MAX_DRAW_CYCLES_DEF,
  parameter int ARM_CYCLES = ARM_CYCLES_DEF
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  catcher_x_i,
  input  logic [6:0]  catcher_y_i,
  input  logic [2:0]  catcher_color_i,
  input  logic        catcher_finish_i,
  input  logic [7:0]  obj_x_i,
  input  logic [6:0]  obj_y_i,
  input  logic [2:0]  obj_color_i,
  input  logic        obj_finish_i,
  output logic        draw_catcher_o,
  output logic        draw_object_o,
  output logic [7:0]  vga_x_o,
  output logic [6:0]  vga_y_o,
  output logic [2:0]  vga_color_o,
  output logic        vga_plot_o,
  output logic        frame_done_o,
  output logic [15:0] frame_count_o,
  output logic        timeout_err_o,
  output logic        frame_overrun_o
);
  localparam int PW = $clog2(MAX_DRAW_CYCLES + 1);
  state_e state_q, state_d;
  logic tick, pending_q, pending_d;
  logic [7:0] cx_q;
  logic [6:0] cy_q;
  logic [PW-1:0] pc_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] color_q;
  logic plot_q, plot_d;
  logic [15:0] frame_count_q;
  logic timeout_q, overrun_q;
  logic drawing, armed, fin, abort, phase_end, clear_last;

  frame_tick_gen #(.TICKS_PER_FRAME(TICKS_PER_FRAME)) u_tick (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .tick_o (tick)
  );

  // finish is only trusted once armed; a stale finish from the last frame is ignored
  assign drawing = is_draw(state_q);
  assign armed = pc_q >= PW'(ARM_CYCLES);
  assign fin = drawing && armed && (state_q == DRAW_CAT ? catcher_finish_i : obj_finish_i);
  assign abort = drawing && !fin && pc_q == PW'(MAX_DRAW_CYCLES - 1);
  assign phase_end = fin || abort;
  assign clear_last = cx_q == 8'(SCREEN_W - 1) && cy_q == 7'(SCREEN_H - 1);
  assign plot_d = drawing && armed && !fin && !abort;
  assign pending_d = (state_q == IDLE || state_q == WAIT_TICK) ? 1'b0 : pending_q || tick;

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = start_i ? CLEAR : IDLE;
      CLEAR:     state_d = clear_last ? WAIT_TICK : CLEAR;
      WAIT_TICK: state_d = !start_i ? IDLE : (tick || pending_q) ? DRAW_CAT : WAIT_TICK;
      DRAW_CAT:  state_d = phase_end ? DRAW_OBJ : DRAW_CAT;
      DRAW_OBJ:  state_d = phase_end ? FRAME_END : DRAW_OBJ;
      FRAME_END: state_d = WAIT_TICK;
      default:   state_d = IDLE;
    endcase
  end

  // clear pixels come straight from the scan counters; client pixels are one cycle late
  always_comb begin
    draw_catcher_o = state_q == DRAW_CAT;
    draw_object_o = state_q == DRAW_OBJ;
    frame_done_o = state_q == FRAME_END;
    vga_plot_o = state_q == CLEAR || plot_q;
    vga_x_o = state_q == CLEAR ? cx_q : x_q;
    vga_y_o = state_q == CLEAR ? cy_q : y_q;
    vga_color_o = state_q == CLEAR ? BLACK : color_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      pc_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      x_q <= '0;
      y_q <= '0;
      color_q <= '0;
      plot_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_q || (tick && state_q != IDLE && state_q != WAIT_TICK);
      timeout_q <= timeout_q || abort;
      pc_q <= (drawing && !phase_end) ? pc_q + 1'b1 : '0;
      cx_q <= (state_q == CLEAR && cx_q != 8'(SCREEN_W - 1)) ? cx_q + 1'b1 : '0;
      cy_q <= (state_q != CLEAR || clear_last) ? '0 :
              cx_q == 8'(SCREEN_W - 1) ? cy_q + 1'b1 : cy_q;
      x_q <= state_q == DRAW_CAT ? catcher_x_i : obj_x_i;
      y_q <= state_q == DRAW_CAT ? catcher_y_i : obj_y_i;
      color_q <= state_q == DRAW_CAT ? catcher_color_i : obj_color_i;
      plot_q <= plot_d;
      frame_count_q <= state_d == FRAME_END ? frame_count_q + 1'b1 : frame_count_q;
    end
  end

  assign frame_count_o = frame_count_q;
  assign timeout_err_o = timeout_q;
  assign frame_overrun_o = overrun_q;
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler: table-driven clear scan, directed frame sequences and randomized
// frames checked against a phase-level model of the scheduler.
module tb_frame_draw_scheduler;
  localparam int TPF = 64;
  localparam int SW = 8;
  localparam int SH = 4;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } vec_t;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  logic start_i = 1'b0;
  logic [7:0] cat_x = '0, obj_x = '0;
  logic [6:0] cat_y = '0, obj_y = '0;
  logic [2:0] cat_c = '0, obj_c = '0;
  logic cat_f = 1'b0, obj_f = 1'b0;
  logic sel = 1'b0;
  wire [39:0] oa, ob;
  logic [39:0] o;
  logic o_dc, o_dob, o_p, o_fd, o_to, o_ovr;
  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_c;
  logic [15:0] o_fc;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, m_fc = 0, m_max = 32;
  bit m_pend = 0, m_ovr = 0, m_to = 0;
  vec_t clr_tab[33];

  always #5 clock_i = ~clock_i;

  frame_draw_scheduler #(.TICKS_PER_FRAME(TPF), .SCREEN_W(SW), .SCREEN_H(SH),
                         .MAX_DRAW_CYCLES(32), .ARM_CYCLES(2)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .catcher_x_i(cat_x), .catcher_y_i(cat_y), .catcher_color_i(cat_c), .catcher_finish_i(cat_f),
    .obj_x_i(obj_x), .obj_y_i(obj_y), .obj_color_i(obj_c), .obj_finish_i(obj_f),
    .draw_catcher_o(oa[39]), .draw_object_o(oa[38]), .vga_x_o(oa[37:30]), .vga_y_o(oa[29:23]),
    .vga_color_o(oa[22:20]), .vga_plot_o(oa[19]), .frame_done_o(oa[18]),
    .frame_count_o(oa[17:2]), .timeout_err_o(oa[1]), .frame_overrun_o(oa[0])
  );

  frame_draw_scheduler #(.TICKS_PER_FRAME(TPF), .SCREEN_W(SW), .SCREEN_H(SH),
                         .MAX_DRAW_CYCLES(128), .ARM_CYCLES(2)) dut_w (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .catcher_x_i(cat_x), .catcher_y_i(cat_y), .catcher_color_i(cat_c), .catcher_finish_i(cat_f),
    .obj_x_i(obj_x), .obj_y_i(obj_y), .obj_color_i(obj_c), .obj_finish_i(obj_f),
    .draw_catcher_o(ob[39]), .draw_object_o(ob[38]), .vga_x_o(ob[37:30]), .vga_y_o(ob[29:23]),
    .vga_color_o(ob[22:20]), .vga_plot_o(ob[19]), .frame_done_o(ob[18]),
    .frame_count_o(ob[17:2]), .timeout_err_o(ob[1]), .frame_overrun_o(ob[0])
  );

  assign o = sel ? ob : oa;
  assign {o_dc, o_dob, o_x, o_y, o_c, o_p, o_fd, o_fc, o_to, o_ovr} = o;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // a tick lands in the cycle where cyc % TPF == TPF-1; outside WAIT_TICK it is an overrun
  task automatic step(input bit waiting);
    if (cyc % TPF == TPF - 1 && !waiting) begin
      m_pend = 1;
      m_ovr = 1;
    end
    @(posedge clock_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    @(posedge clock_i);
    #1;
    chk("reset_outputs", o, 40'h0);
    reset_i = 1'b0;
    start_i = 1'b1;
    cyc = 0;
    m_fc = 0;
    m_pend = 0;
    m_ovr = 0;
    m_to = 0;
  endtask

  task automatic check_clear();
    step(1);
    for (int i = 0; i < 33; i++) begin
      if (clr_tab[i].p) chk($sformatf("clear_px%0d", i), {o_x, o_y, o_c}, {clr_tab[i].x, clr_tab[i].y, clr_tab[i].c});
      chk($sformatf("clear_plot%0d", i), o_p, clr_tab[i].p);
      if (i < 32) step(0);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    int exp = m_pend ? 1 : TPF - cyc % TPF;
    while (!o_dc && n < 200) begin
      step(1);
      n++;
    end
    chk("frame_start_delay", n, exp);
    m_pend = 0;
  endtask

  // f: first armed phase cycle with finish=1; s0/s1: stale finish values in cycles 0 and 1
  task automatic run_phase(input bit is_obj, input int f, input bit s0, input bit s1);
    int e = f < m_max - 1 ? f : m_max - 1;
    int bad = 0, nplot = 0, obs = 0;
    bit pv = 0, fin;
    logic [17:0] px = '0, r;
    for (int k = 0; k <= e; k++) begin
      if (is_obj ? (!o_dob || o_dc) : (!o_dc || o_dob)) bad++;
      if (o_p !== pv || (pv && {o_x, o_y, o_c} !== px)) bad++;
      obs += int'(o_p);
      fin = k == 0 ? s0 : k == 1 ? s1 : k >= f;
      r = 18'($urandom);
      {cat_x, cat_y, cat_c} = is_obj ? 18'($urandom) : r;
      {obj_x, obj_y, obj_c} = is_obj ? r : 18'($urandom);
      cat_f = is_obj ? 1'($urandom) : fin;
      obj_f = is_obj ? fin : 1'($urandom);
      pv = k >= 2 && k < f && k < m_max - 1;
      px = r;
      nplot += int'(pv);
      step(0);
    end
    if (f > m_max - 1) m_to = 1;
    chk(is_obj ? "obj_enable_drop" : "cat_enable_drop", is_obj ? o_dob : o_dc, 0);
    chk("phase_stream", bad, 0);
    chk("plot_count", obs, nplot);
    chk("timeout_err", o_to, m_to);
  endtask

  task automatic frame_end_chk();
    m_fc++;
    chk("frame_done", o_fd, 1);
    chk("frame_count", o_fc, 64'(m_fc % 65536));
    chk("frame_end_plot", o_p, 0);
    step(0);
    chk("frame_done_pulse", o_fd, 0);
    chk("frame_overrun", o_ovr, m_ovr);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 33; i++) begin
      clr_tab[i].x = 8'(i % SW);
      clr_tab[i].y = 7'(i / SW);
      clr_tab[i].c = 3'b000;
      clr_tab[i].p = i < 32;
    end
    repeat (2) @(posedge clock_i);
    #1;
    do_reset();
    check_clear();
    wait_frame();
    run_phase(0, 23, 1, 0);
    run_phase(1, 2, 1, 1);
    frame_end_chk();
    wait_frame();
    run_phase(0, 5, 0, 1);
    run_phase(1, 1000, 0, 0);
    frame_end_chk();
    wait_frame();
    run_phase(0, 4, 1, 1);
    obj_f = 1'b0;
    repeat (3) step(0);
    do_reset();
    check_clear();
    wait_frame();
    for (int fr = 0; fr < 10; fr++) begin
      run_phase(0, int'($urandom_range(2, 40)), 1'($urandom), 1'($urandom));
      if (fr == 9) start_i = 1'b0;
      run_phase(1, int'($urandom_range(2, 40)), 1'($urandom), 1'($urandom));
      frame_end_chk();
      if (fr < 9) wait_frame();
    end
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      if (o_dc || o_dob || o_p) bad++;
      step(1);
    end
    chk("idle_hold", bad, 0);
    m_pend = 0;
    start_i = 1'b1;
    check_clear();
    wait_frame();
    sel = 1'b1;
    m_max = 128;
    do_reset();
    check_clear();
    wait_frame();
    run_phase(0, 70, 1, 1);
    run_phase(1, 2, 0, 0);
    frame_end_chk();
    chk("overrun_set", o_ovr, 1);
    wait_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
